// File: rtl/yt_key_event_master.sv
// Avalon-MM initiator servicing a 2-bit key PIO: programs irq_mask, drains edge_capture,
// reads key level and reports one-cycle key events followed by a bounce holdoff.
module yt_key_event_master #(
   parameter logic [1:0]  MASK_INIT   = 2'b11,
   parameter int unsigned POLL_PERIOD = 50000,
   parameter int unsigned HOLDOFF     = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        irq,
   output logic [1:0]  address,
   output logic        chipselect,
   output logic        write_n,
   output logic [31:0] writedata,
   input  logic [31:0] readdata,
   input  logic        mask_wr,
   input  logic [1:0]  mask_data,
   output logic        evt_valid,
   output logic [1:0]  evt_edges,
   output logic [1:0]  evt_level,
   output logic [15:0] evt_count,
   output logic        busy
);

   localparam logic [31:0] POLL_LAST = 32'(POLL_PERIOD - 1);
   localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF);

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_MASK, S_RD_EDGE, S_WT_EDGE,
      S_CLR, S_RD_LVL, S_WT_LVL, S_REPORT, S_HOLD
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] poll_q, poll_d;
   logic [31:0] hold_q, hold_d;
   logic        pend_q, pend_d;
   logic [1:0]  mask_q, mask_d;
   logic [1:0]  edges_q, edges_d;
   logic [1:0]  level_q, level_d;
   logic        cs_q, cs_d;
   logic        wn_q, wn_d;
   logic [1:0]  addr_q, addr_d;
   logic [31:0] wd_q, wd_d;
   logic        evt_valid_q, evt_valid_d;
   logic [1:0]  evt_edges_q, evt_edges_d;
   logic [1:0]  evt_level_q, evt_level_d;
   logic [15:0] count_q, count_d;
   logic        unused_rd;

   assign unused_rd = ^readdata[31:2];

   // Bus registers are loaded on the edge that enters an access state, so each access
   // is on the bus exactly during that state's cycle; HOLD spans the report cycle plus HOLDOFF.
   always_comb begin
      state_d     = state_q;
      poll_d      = '0;
      hold_d      = '0;
      pend_d      = pend_q;
      mask_d      = mask_q;
      edges_d     = edges_q;
      level_d     = level_q;
      evt_valid_d = 1'b0;
      evt_edges_d = evt_edges_q;
      evt_level_d = evt_level_q;
      count_d     = count_q;
      cs_d        = 1'b0;
      wn_d        = 1'b1;
      addr_d      = '0;
      wd_d        = '0;
      case (state_q)
         S_INIT: begin
            state_d = S_IDLE;
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            addr_d  = 2'd2;
            wd_d    = {30'd0, MASK_INIT};
         end
         S_IDLE: begin
            if (pend_q) begin
               state_d = S_MASK;
               pend_d  = 1'b0;
               cs_d    = 1'b1;
               wn_d    = 1'b0;
               addr_d  = 2'd2;
               wd_d    = {30'd0, mask_q};
            end else if (irq || (POLL_PERIOD != 0 && poll_q == POLL_LAST)) begin
               state_d = S_RD_EDGE;
               cs_d    = 1'b1;
               addr_d  = 2'd3;
            end else begin
               poll_d = poll_q + 32'd1;
            end
         end
         S_MASK:    state_d = S_IDLE;
         S_RD_EDGE: state_d = S_WT_EDGE;
         S_WT_EDGE: begin
            edges_d = readdata[1:0];
            state_d = S_CLR;
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            addr_d  = 2'd3;
         end
         S_CLR: begin
            state_d = S_RD_LVL;
            cs_d    = 1'b1;
            addr_d  = 2'd0;
         end
         S_RD_LVL:  state_d = S_WT_LVL;
         S_WT_LVL: begin
            level_d = readdata[1:0];
            state_d = S_REPORT;
         end
         S_REPORT: begin
            evt_valid_d = 1'b1;
            evt_edges_d = edges_q;
            evt_level_d = level_q;
            count_d     = count_q + {15'd0, |edges_q};
            state_d     = S_HOLD;
         end
         S_HOLD: begin
            if (hold_q == HOLD_LAST) state_d = S_IDLE;
            else                     hold_d  = hold_q + 32'd1;
         end
         default: state_d = S_INIT;
      endcase
      if (mask_wr) begin
         pend_d = 1'b1;
         mask_d = mask_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_INIT;
         poll_q      <= '0;
         hold_q      <= '0;
         pend_q      <= 1'b0;
         mask_q      <= '0;
         edges_q     <= '0;
         level_q     <= '0;
         cs_q        <= 1'b0;
         wn_q        <= 1'b1;
         addr_q      <= '0;
         wd_q        <= '0;
         evt_valid_q <= 1'b0;
         evt_edges_q <= '0;
         evt_level_q <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         poll_q      <= poll_d;
         hold_q      <= hold_d;
         pend_q      <= pend_d;
         mask_q      <= mask_d;
         edges_q     <= edges_d;
         level_q     <= level_d;
         cs_q        <= cs_d;
         wn_q        <= wn_d;
         addr_q      <= addr_d;
         wd_q        <= wd_d;
         evt_valid_q <= evt_valid_d;
         evt_edges_q <= evt_edges_d;
         evt_level_q <= evt_level_d;
         count_q     <= count_d;
      end
   end

   assign chipselect = cs_q;
   assign write_n    = wn_q;
   assign address    = addr_q;
   assign writedata  = wd_q;
   assign evt_valid  = evt_valid_q;
   assign evt_edges  = evt_edges_q;
   assign evt_level  = evt_level_q;
   assign evt_count  = count_q;
   assign busy       = (state_q != S_IDLE);

endmodule
